// File: rtl/debug_trace_buf.sv
// Circular trace buffer for a CPU debug port: captures {inst, data} samples around
// a trigger, then replays the held window oldest-first over a valid/ready port.
module debug_trace_buf #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       trig,
  input  logic                       smp_valid,
  input  logic [DATA_W-1:0]          smp_inst,
  input  logic [DATA_W-1:0]          smp_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_inst,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_last,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [2:0]                 dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_V   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_POST = 3'd2,
    S_DONE = 3'd3,
    S_READ = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]         fill_q, fill_d;
  logic [AW-1:0]       post_cnt_q, post_cnt_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         rem_q, rem_d;
  logic [DATA_W-1:0]   rd_inst_q, rd_inst_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_last_q, rd_last_d;

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic                wr_en;
  logic [AW-1:0]       rd_addr;
  logic [2*DATA_W-1:0] rd_word;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (arm) state_d = S_PRE;
      S_PRE:  if (smp_valid && trig) state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
      S_POST: if (smp_valid && post_cnt_q == AW'(1)) state_d = S_DONE;
      S_DONE: state_d = S_READ;
      S_READ: if (rd_ready && rd_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_en   = smp_valid && (state_q == S_PRE || state_q == S_POST);
  // In DONE the oldest entry sits fill slots behind the write pointer; fill=DEPTH wraps to it.
  assign rd_addr = (state_q == S_DONE) ? (wr_ptr_q - fill_q[AW-1:0]) : rd_ptr_q;
  assign rd_word = mem_q[rd_addr];

  // Datapath next values
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    post_cnt_d = post_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    rd_inst_d  = rd_inst_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;

    if (state_q == S_IDLE && arm) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fill_q != DEPTH_V) fill_d = fill_q + (AW+1)'(1);
      if (state_q == S_PRE && trig) post_cnt_d = POST_INIT;
      if (state_q == S_POST)        post_cnt_d = post_cnt_q - AW'(1);
    end

    if (state_q == S_DONE) begin
      rd_inst_d = rd_word[2*DATA_W-1:DATA_W];
      rd_data_d = rd_word[DATA_W-1:0];
      rd_last_d = (fill_q == (AW+1)'(1));
      rd_ptr_d  = rd_addr + AW'(1);
      rem_d     = fill_q;
    end

    // Transfer on rd_valid & rd_ready; rd_* stay frozen while rd_ready is low.
    if (state_q == S_READ && rd_ready) begin
      if (rd_last_q) begin
        rd_last_d = 1'b0;
      end else begin
        rd_inst_d = rd_word[2*DATA_W-1:DATA_W];
        rd_data_d = rd_word[DATA_W-1:0];
        rd_last_d = (rem_q == (AW+1)'(2));
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rem_d     = rem_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      post_cnt_q <= '0;
      rd_ptr_q   <= '0;
      rem_q      <= '0;
      rd_inst_q  <= '0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      post_cnt_q <= post_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      rem_q      <= rem_d;
      rd_inst_q  <= rd_inst_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Storage is never reset; fill gates what can be read back.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {smp_inst, smp_data};
  end

  // Output logic
  always_comb begin
    rd_valid  = (state_q == S_READ);
    busy      = (state_q == S_PRE) || (state_q == S_POST);
    done      = (state_q == S_DONE) || (state_q == S_READ);
    rd_inst   = rd_inst_q;
    rd_data   = rd_data_q;
    rd_last   = rd_last_q;
    fill      = fill_q;
    dbg_state = state_q;
  end

endmodule

// File: doc/debug_trace_buf.md
DEBUG_TRACE_BUF -- requirements
Module: debug_trace_buf

Interface
REQ-001 Parameter DATA_W, default 32, width of each captured instruction and data word.
REQ-002 Parameter DEPTH, default 16, number of trace entries; SHALL be a power of two and at least 2.
REQ-003 Parameter POST_TRIG, default 4, number of samples captured after the trigger sample; legal range 0..DEPTH-1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 arm  in  1  starts a capture run; honoured only in IDLE.
REQ-007 trig  in  1  trigger qualifier; honoured only in PRE with smp_valid=1.
REQ-008 smp_valid  in  1  sample strobe from the CPU debug port.
REQ-009 smp_inst  in  DATA_W  instruction word to capture.
REQ-010 smp_data  in  DATA_W  data word to capture.
REQ-011 rd_ready  in  1  consumer accepts the current readout entry.
REQ-012 rd_valid  out  1  readout entry valid.
REQ-013 rd_inst  out  DATA_W  readout instruction word.
REQ-014 rd_data  out  DATA_W  readout data word.
REQ-015 rd_last  out  1  current readout entry is the final one.
REQ-016 busy  out  1  high in PRE and POST.
REQ-017 done  out  1  high in DONE and READ.
REQ-018 fill  out  $clog2(DEPTH)+1  number of valid entries held.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, PRE, POST, DONE and READ.
REQ-020 IDLE: arm=1 -> PRE; write pointer and fill cleared; a smp_valid in that same cycle is not captured.
REQ-021 PRE: each smp_valid writes {smp_inst, smp_data} at the write pointer; pointer increments modulo DEPTH; fill increments and saturates at DEPTH, oldest entry overwritten on wrap.
REQ-022 PRE: smp_valid=1 and trig=1 -> the trigger sample is written; next state POST with post counter = POST_TRIG, or DONE if POST_TRIG=0.
REQ-023 PRE: trig=1 with smp_valid=0 has no effect.
REQ-024 POST: each smp_valid writes as in PRE and decrements the post counter; the write that brings it to 0 moves the FSM to DONE; trig is ignored.
REQ-025 DONE lasts exactly one cycle: read pointer = (write pointer - fill) mod DEPTH; the oldest entry is loaded into the rd_* registers; next state READ.
REQ-026 READ: rd_valid=1; entries are presented oldest-first; a transfer occurs on rd_valid & rd_ready.
REQ-027 rd_inst, rd_data and rd_last SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-028 After a transfer, the next entry appears on the following cycle with no bubble; rd_last=1 exactly on the fill-th entry.
REQ-029 The transfer of the rd_last entry SHALL return the FSM to IDLE with rd_valid=0 on the next cycle; fill is retained until the next arm.
REQ-030 arm outside IDLE SHALL be ignored; smp_valid outside PRE/POST SHALL be ignored.
REQ-031 fill SHALL be at least 1 on entry to DONE, because the trigger sample is always written.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, with rd_valid=0, rd_last=0, busy=0, done=0, fill=0, rd_inst=0, rd_data=0, and pointers and counters cleared, regardless of the current state.
REQ-033 Memory contents need not be cleared; no stale entry SHALL be readable after reset.

Verification
REQ-034 Default parameters; arm; samples inst=data=1..3; sample 4 with trig; samples 5..8 -> DONE after sample 8, fill=8, readout 1..8 in order, rd_last only on 8, then IDLE.
REQ-035 Wrap: arm; samples 1..20; trig on 21; samples 22..25 -> fill=16, readout 10..25, rd_last on 25.
REQ-036 Backpressure: hold rd_ready=0 for 3 cycles on entry 2 -> rd_inst and rd_data stay 2 and rd_valid stays 1; readout then resumes at 3 with no loss or duplication.
REQ-037 POST_TRIG=0 instance: arm; sample 7 with trig -> fill=1, single readout entry 7 with rd_last=1.
REQ-038 trig with smp_valid=0 in PRE -> state remains PRE; arm during POST -> ignored; arm coinciding with a sample in IDLE -> sample not stored.
REQ-039 Assert reset=0 in POST after 5 samples -> all outputs reach their reset values asynchronously; the next run starts with fill=0 and reads back only new samples.
